seg7_scan_mux: RTL

- Parametrised multi-digit 7-segment display driver. Successor to the single-digit BCD decoder.
- Latches N_DIGITS nibbles, each with a per-digit blank flag and blink flag, on a load strobe.
- Time-multiplexes the digits onto one shared segment bus with per-digit anode enables, with dead-time between digits and hardware blink.
- Adds a hex mode. Sits between the game controller (score/level/sequence display) and the board display pins.

---
 rtl/seg7_scan_mux.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multi-digit 7-segment scan driver.
// Latches N_DIGITS nibbles with per-digit blank/blink flags on a load strobe,
// then time-multiplexes them onto one shared segment bus with one-hot anode
// enables, a dark dead-time at the start of every slot, and hardware blink.
module seg7_scan_mux #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYC     = 2,
  parameter int BLINK_FRAMES = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  input  logic [N_DIGITS-1:0]     blink_in,
  input  logic                    hex_mode,
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [PS_W-1:0]  PS_DEAD  = PS_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  // Scan timing state
  logic [PS_W-1:0]  prescaler_q, prescaler_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_q, frame_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             phase_q, phase_d;   // 1 = blinking digits visible

  // Shadow copies of the display contents
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   blank_q, blank_d;
  logic [N_DIGITS-1:0]   blink_q, blink_d;

  // Registered pin drivers
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  // Per-slot selections from the shadow registers
  logic                tick;
  logic                wrap;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic                cur_blink;
  logic [N_DIGITS-1:0] cur_onehot;
  logic                dark;

  // Nibble to segment pattern; values 10..15 only light up in hex mode.
  function automatic logic [6:0] decode(input logic [3:0] v, input logic hex);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    if (!hex && (v > 4'd9)) begin
      s = 7'b0000000;
    end
    return s;
  endfunction

  // Select the current digit's nibble, flags and anode position
  always_comb begin
    cur_nib    = 4'h0;
    cur_blank  = 1'b0;
    cur_blink  = 1'b0;
    cur_onehot = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib       = digits_q[4*k +: 4];
        cur_blank     = blank_q[k];
        cur_blink     = blink_q[k];
        cur_onehot[k] = 1'b1;
      end
    end
  end

  // Next-state: prescaler, digit index, frame pulse, blink timing, shadow, outputs
  always_comb begin
    tick = (prescaler_q == PS_LAST);
    wrap = tick && (idx_q == IDX_LAST);

    prescaler_d = tick ? '0 : prescaler_q + 1'b1;

    idx_d = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    frame_d = wrap;

    // Blink phase flips once every BLINK_FRAMES completed scans
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (wrap) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    // A load never touches scan position; coincident with tick the new data
    // is already in place for the following slot.
    digits_d = load ? digits_in : digits_q;
    blank_d  = load ? blank_in  : blank_q;
    blink_d  = load ? blink_in  : blink_q;

    // Outputs reflect the current prescaler/idx and appear one cycle later
    dark = (prescaler_q < PS_DEAD) || cur_blank || (cur_blink && !phase_q);
    if (dark) begin
      seg_d = 7'b0000000;
      an_d  = '0;
    end else begin
      seg_d = decode(cur_nib, hex_mode);
      an_d  = cur_onehot;
    end
  end

  // State and output registers; reset clears everything, blink starts visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      frame_q     <= 1'b0;
      fcnt_q      <= '0;
      phase_q     <= 1'b1;
      digits_q    <= '0;
      blank_q     <= '0;
      blink_q     <= '0;
      seg_q       <= 7'b0000000;
      an_q        <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      fcnt_q      <= fcnt_d;
      phase_q     <= phase_d;
      digits_q    <= digits_d;
      blank_q     <= blank_d;
      blink_q     <= blink_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule
